// File: rtl/spi_pkg.sv
// Shared types for the SPI slave frame controller: FSM states and command codes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RX,
    ST_WAIT_TX,
    ST_TX,
    ST_DONE
  } spi_state_e;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first parallel-load shift register driving a registered miso.
// load puts the MSB on miso the next cycle; shift advances one bit; otherwise miso clears.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              miso
);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_shift;

  assign sr_shift = sr << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      miso <= 1'b0;
    end else if (load) begin
      sr   <= data;
      miso <= data[DATA_W-1];
    end else if (shift) begin
      // sr_shift is empty after DATA_W shifts, so miso falls to 0 by itself
      sr   <= sr_shift;
      miso <= sr_shift[DATA_W-1];
    end else begin
      sr   <= '0;
      miso <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame controller: {cmd, payload} word out after CMD_W+DATA_W+1 cycles, read data shifted on miso.
// Read response waits indefinitely for tx_valid; optional even parity bit enabled by SPI_PARITY_EN.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int CMD_W  = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(CMD_W + DATA_W + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    busy,
  output logic                    rx_err
);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  spi_state_e              state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [CMD_W-1:0]        cmd_q, cmd_n;
  logic [DATA_W-1:0]       pay_q, pay_n;
  logic [CMD_W+DATA_W-1:0] rx_data_n;
  logic                    rx_valid_n;
  logic                    is_rd;
  logic                    tx_load, tx_shift;

  assign is_rd = spi_cmd_e'(cmd_q[CMD_W-1 -: 2]) == CMD_RD_DATA;
  assign busy  = state != ST_IDLE;

`ifdef SPI_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_SLOT = CNT_W'(DATA_W);
  logic rx_err_q, rx_err_n;
  assign rx_err = rx_err_q;
`else
  assign rx_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cmd_q    <= '0;
      pay_q    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cmd_q    <= cmd_n;
      pay_q    <= pay_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
    end
  end

`ifdef SPI_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) rx_err_q <= 1'b0;
    else     rx_err_q <= rx_err_n;
  end
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cmd_n      = cmd_q;
    pay_n      = pay_q;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
`ifdef SPI_PARITY_EN
    rx_err_n   = 1'b0;
`endif
    // ss_n high aborts every active phase; abort wins over a completing bit
    case (state)
      ST_IDLE: begin
        if (!ss_n) state_n = ST_CMD;
      end
      ST_CMD: begin
        if (ss_n) state_n = ST_IDLE;
        else begin
          cmd_n = (cmd_q << 1) | CMD_W'(mosi);
          if (cnt == CMD_LAST) state_n = ST_RX;
        end
      end
      ST_RX: begin
        if (ss_n) state_n = ST_IDLE;
`ifdef SPI_PARITY_EN
        else if (cnt == PAR_SLOT) begin
          if (^{cmd_q, pay_q, mosi}) begin
            rx_err_n = 1'b1;
            state_n  = ST_DONE;
          end else begin
            rx_valid_n = 1'b1;
            rx_data_n  = {cmd_q, pay_q};
            state_n    = is_rd ? ST_WAIT_TX : ST_DONE;
          end
        end else begin
          pay_n = (pay_q << 1) | DATA_W'(mosi);
        end
`else
        else begin
          pay_n = (pay_q << 1) | DATA_W'(mosi);
          if (cnt == DATA_LAST) begin
            rx_valid_n = 1'b1;
            rx_data_n  = {cmd_q, pay_n};
            state_n    = is_rd ? ST_WAIT_TX : ST_DONE;
          end
        end
`endif
      end
      ST_WAIT_TX: begin
        if (ss_n) state_n = ST_IDLE;
        else if (tx_valid) begin
          tx_load = 1'b1;
          state_n = ST_TX;
        end
      end
      ST_TX: begin
        if (ss_n) state_n = ST_IDLE;
        else begin
          tx_shift = 1'b1;
          if (cnt == DATA_LAST) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ss_n) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state) cnt_n = '0;
    else if (state == ST_CMD || state == ST_RX || state == ST_TX) cnt_n = cnt + CNT_W'(1);
  end

  spi_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .shift(tx_shift),
    .data (tx_data),
    .miso (miso)
  );

endmodule
